// File: rtl/binarization_pkg.sv
// Shared types for the bin-level debinarizers: FSM states and binarization mode encodings.
package binarization_pkg;

    typedef enum logic [1:0] {
        StIdle   = 2'd0,
        StDecode = 2'd1,
        StDone   = 2'd2
    } state_e;

    localparam logic MODE_TRU   = 1'b0;
    localparam logic MODE_UNARY = 1'b1;

endpackage

// File: rtl/unary_tru_debinarizer_if.sv
// Handshake/result bundle between a bin source and the unary/TRU debinarizer.
interface unary_tru_debinarizer_if #(
    parameter int unsigned VALUE_WIDTH = 8,
    parameter int unsigned CMAX_WIDTH  = 3
) ();

    logic                   start_i;
    logic                   sel_i;
    logic [CMAX_WIDTH-1:0]  cmax_i;
    logic                   bin_i;
    logic                   bin_valid_i;
    logic                   bin_ready_o;
    logic [VALUE_WIDTH-1:0] value_o;
    logic [VALUE_WIDTH:0]   bin_count_o;
    logic                   done_o;
    logic                   error_o;

    modport master (
        output start_i, sel_i, cmax_i, bin_i, bin_valid_i,
        input  bin_ready_o, value_o, bin_count_o, done_o, error_o
    );

    modport slave (
        input  start_i, sel_i, cmax_i, bin_i, bin_valid_i,
        output bin_ready_o, value_o, bin_count_o, done_o, error_o
    );

endinterface

// File: rtl/unary_tru_debinarizer.sv
// Serial unary / truncated-unary debinarizer: counts leading 1 bins until a 0 bin,
// the cMax limit (TRU) or value overflow (unary) terminates the decode.
module unary_tru_debinarizer
    import binarization_pkg::*;
#(
    parameter int unsigned VALUE_WIDTH = 8,
    parameter int unsigned CMAX_WIDTH  = 3
) (
    input logic                     clk,
    input logic                     rst,
    unary_tru_debinarizer_if.slave  bus
);

    localparam logic [VALUE_WIDTH-1:0] ValueMax = '1;
    localparam logic [VALUE_WIDTH-1:0] ValueOne = VALUE_WIDTH'(1);
    localparam logic [VALUE_WIDTH:0]   CountOne = (VALUE_WIDTH + 1)'(1);

    state_e                 r_state;
    state_e                 w_state_next;
    logic                   r_sel;
    logic                   w_sel_next;
    logic [CMAX_WIDTH-1:0]  r_cmax;
    logic [CMAX_WIDTH-1:0]  w_cmax_next;
    logic [VALUE_WIDTH-1:0] r_value;
    logic [VALUE_WIDTH-1:0] w_value_next;
    logic [VALUE_WIDTH:0]   r_count;
    logic [VALUE_WIDTH:0]   w_count_next;
    logic                   r_error;
    logic                   w_error_next;

    logic                   w_ready;
    logic                   w_accept;
    logic [VALUE_WIDTH-1:0] w_cmax_ext;

    assign w_cmax_ext = VALUE_WIDTH'(r_cmax);

    always_comb begin
        w_state_next = r_state;
        w_sel_next   = r_sel;
        w_cmax_next  = r_cmax;
        w_value_next = r_value;
        w_count_next = r_count;
        w_error_next = r_error;

        // A new start wins over a bin offered in the same cycle, so ready drops with it.
        w_ready  = (r_state == StDecode) && !bus.start_i;
        w_accept = w_ready && bus.bin_valid_i;

        if (bus.start_i) begin
            w_sel_next   = bus.sel_i;
            w_cmax_next  = bus.cmax_i;
            w_value_next = '0;
            w_count_next = '0;
            w_error_next = 1'b0;
            if ((bus.sel_i == MODE_TRU) && (bus.cmax_i == '0)) begin
                w_state_next = StDone;
            end else begin
                w_state_next = StDecode;
            end
        end else if (w_accept) begin
            w_count_next = r_count + CountOne;
            if (!bus.bin_i) begin
                w_state_next = StDone;
            end else if (r_value == ValueMax) begin
                // Overflowing 1 bin: value stays saturated and the decode is flagged.
                w_error_next = 1'b1;
                w_state_next = StDone;
            end else begin
                w_value_next = r_value + ValueOne;
                if ((r_sel == MODE_TRU) && (w_value_next == w_cmax_ext)) begin
                    w_state_next = StDone;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= StIdle;
            r_sel   <= MODE_TRU;
            r_cmax  <= '0;
            r_value <= '0;
            r_count <= '0;
            r_error <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_sel   <= w_sel_next;
            r_cmax  <= w_cmax_next;
            r_value <= w_value_next;
            r_count <= w_count_next;
            r_error <= w_error_next;
        end
    end

    assign bus.bin_ready_o = w_ready;
    assign bus.value_o     = r_value;
    assign bus.bin_count_o = r_count;
    assign bus.done_o      = (r_state == StDone);
    assign bus.error_o     = r_error;

endmodule

// File: tb/tb_unary_tru_debinarizer.sv
// Randomized bench for unary_tru_debinarizer, checked every cycle against a result-level model.
module tb_unary_tru_debinarizer;
    import binarization_pkg::*;

    localparam int unsigned VW   = 8;
    localparam int unsigned CW   = 3;
    localparam int          VMAX = (1 << VW) - 1;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    unary_tru_debinarizer_if #(.VALUE_WIDTH(VW), .CMAX_WIDTH(CW)) bus ();

    unary_tru_debinarizer #(.VALUE_WIDTH(VW), .CMAX_WIDTH(CW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int checks = 0;
    int errors = 0;

    // Model: the whole transaction result is predicted up front from the bin stream.
    bit m_active = 1'b0;
    int m_consumed = 0;
    int m_exp_value = 0;
    int m_exp_count = 0;
    bit m_exp_error = 1'b0;
    bit cur_stream[$];
    bit next_stream[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic void predict(input bit sel, input int cmax);
        int n = 0;
        while (n < cur_stream.size() && cur_stream[n]) n++;
        m_exp_error = 1'b0;
        if (sel == MODE_TRU) begin
            if (n >= cmax) begin
                m_exp_value = cmax;
                m_exp_count = cmax;
            end else begin
                m_exp_value = n;
                m_exp_count = n + 1;
            end
        end else if (n > VMAX) begin
            m_exp_value = VMAX;
            m_exp_count = VMAX + 1;
            m_exp_error = 1'b1;
        end else begin
            m_exp_value = n;
            m_exp_count = n + 1;
        end
    endfunction

    task automatic cycle(input bit start, input bit sel, input int cmax, input bit valid);
        bit exp_ready;
        bit exp_done;
        @(negedge clk);
        bus.start_i     = start;
        bus.sel_i       = sel;
        bus.cmax_i      = CW'(cmax);
        bus.bin_valid_i = valid;
        bus.bin_i       = (m_consumed < cur_stream.size()) ? cur_stream[m_consumed]
                                                           : 1'($urandom);
        #1;
        exp_ready = m_active && !start && (m_consumed < m_exp_count);
        exp_done  = m_active && (m_consumed == m_exp_count);
        check("bin_ready_o", bus.bin_ready_o, exp_ready);
        check("done_o", bus.done_o, exp_done);
        if (!m_active) begin
            check("idle_value", bus.value_o, 0);
            check("idle_count", bus.bin_count_o, 0);
            check("idle_error", bus.error_o, 0);
        end else if (exp_done) begin
            check("value_o", bus.value_o, m_exp_value);
            check("bin_count_o", bus.bin_count_o, m_exp_count);
            check("error_o", bus.error_o, m_exp_error);
        end else begin
            // Mid-decode every consumed bin was a 1.
            check("run_value", bus.value_o, m_consumed);
            check("run_count", bus.bin_count_o, m_consumed);
            check("run_error", bus.error_o, 0);
        end
        @(posedge clk);
        if (start) begin
            m_active   = 1'b1;
            m_consumed = 0;
            cur_stream = next_stream;
            predict(sel, cmax);
        end else if (exp_ready && valid) begin
            m_consumed++;
        end
    endtask

    // vmode: 0 random valid, 1 valid every other cycle, 2 valid always.
    task automatic run_txn(input bit sel, input int cmax, input int vmode,
                           input int stop_after, input int tail);
        int guard = 0;
        int ph = 0;
        bit v;
        cycle(1'b1, sel, cmax, 1'($urandom));
        while (m_consumed < m_exp_count && (stop_after < 0 || m_consumed < stop_after)) begin
            case (vmode)
                0:       v = ($urandom_range(0, 9) < 7);
                1:       v = (ph % 2 == 1);
                default: v = 1'b1;
            endcase
            ph++;
            cycle(1'b0, sel, cmax, v);
            guard++;
            if (guard > 3000) begin
                checks++;
                errors++;
                $display("FAIL txn_timeout: consumed %0d, expected %0d", m_consumed, m_exp_count);
                break;
            end
        end
        repeat (tail) cycle(1'b0, 1'($urandom), $urandom_range(0, 7), 1'b1);
    endtask

    task automatic pin(input string name, input int v, input int c, input bit e);
        @(negedge clk);
        bus.start_i     = 1'b0;
        bus.bin_valid_i = 1'b0;
        #1;
        check({name, "_done"}, bus.done_o, 1);
        check({name, "_value"}, bus.value_o, v);
        check({name, "_count"}, bus.bin_count_o, c);
        check({name, "_error"}, bus.error_o, e);
    endtask

    task automatic pulse_reset(input int cycles);
        @(negedge clk);
        rst             = 1'b1;
        bus.start_i     = 1'b0;
        bus.bin_valid_i = 1'b0;
        #1;
        m_active   = 1'b0;
        m_consumed = 0;
        check("rst_ready", bus.bin_ready_o, 0);
        check("rst_done", bus.done_o, 0);
        check("rst_value", bus.value_o, 0);
        check("rst_count", bus.bin_count_o, 0);
        check("rst_error", bus.error_o, 0);
        repeat (cycles) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    function automatic void fill(input int ones, input bit zero_after);
        next_stream.delete();
        for (int i = 0; i < ones; i++) next_stream.push_back(1'b1);
        if (zero_after) next_stream.push_back(1'b0);
        for (int i = 0; i < 4; i++) next_stream.push_back(1'($urandom));
    endfunction

    initial begin
        bus.start_i     = 1'b0;
        bus.sel_i       = 1'b0;
        bus.cmax_i      = '0;
        bus.bin_i       = 1'b0;
        bus.bin_valid_i = 1'b0;
        pulse_reset(3);
        repeat (3) cycle(1'b0, 1'b0, 0, 1'b1);

        // TRU cMax=5, 1,1,1,0
        fill(3, 1'b1);
        run_txn(MODE_TRU, 5, 2, -1, 3);
        pin("tru_3", 3, 4, 1'b0);

        // TRU cMax=5, five 1s reach the limit; sixth 1 must stay unconsumed
        fill(6, 1'b0);
        run_txn(MODE_TRU, 5, 2, -1, 4);
        pin("tru_cmax", 5, 5, 1'b0);

        // Unary 1x7 then 0 with gapped valid
        fill(7, 1'b1);
        run_txn(MODE_UNARY, 0, 1, -1, 2);
        pin("unary_7", 7, 8, 1'b0);

        // TRU cMax=0 finishes with no bins
        fill(2, 1'b1);
        run_txn(MODE_TRU, 0, 2, -1, 3);
        pin("tru_cmax0", 0, 0, 1'b0);

        // Unary 255 ones then 0: largest value without overflow
        fill(255, 1'b1);
        run_txn(MODE_UNARY, 0, 2, -1, 2);
        pin("unary_255", 255, 256, 1'b0);

        // Unary 256 ones: overflow
        fill(256, 1'b1);
        run_txn(MODE_UNARY, 0, 2, -1, 2);
        pin("unary_ovf", 255, 256, 1'b1);

        // Reset after two accepted 1s, then a fresh decode of a single 0
        fill(3, 1'b1);
        run_txn(MODE_TRU, 5, 2, 2, 0);
        pulse_reset(2);
        repeat (4) cycle(1'b0, 1'b0, 3, 1'b1);
        fill(0, 1'b1);
        run_txn(MODE_UNARY, 0, 0, -1, 1);
        pin("after_rst", 0, 1, 1'b0);

        // Random mix, with aborted decodes restarted by start_i and occasional resets
        for (int t = 0; t < 150; t++) begin
            int  ones;
            int  r;
            bit  sel;
            int  cmax;
            r    = $urandom_range(0, 19);
            sel  = 1'($urandom);
            cmax = $urandom_range(0, 7);
            ones = (r == 0) ? $urandom_range(250, 270) : $urandom_range(0, 12);
            fill(ones, 1'b1);
            if (r == 1) begin
                run_txn(sel, cmax, 0, $urandom_range(0, 3), 0);
                pulse_reset($urandom_range(1, 3));
                repeat (2) cycle(1'b0, 1'b0, 0, 1'($urandom));
            end else if (r < 5) begin
                run_txn(sel, cmax, 0, $urandom_range(0, 4), 0);
            end else begin
                run_txn(sel, cmax, 0, -1, $urandom_range(0, 3));
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/unary_tru_debinarizer.md
UNARY_TRU_DEBINARIZER -- requirements
Module: unary_tru_debinarizer

Interface
REQ-001 SHALL have parameter VALUE_WIDTH, default 8, width of the decoded value.
REQ-002 SHALL have parameter CMAX_WIDTH, default 3, width of the cMax input.
REQ-003 SHALL have port clk  input  1  sole clock; all state on rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port start_i  input  1  begins a new decode; samples sel_i and cmax_i.
REQ-006 SHALL have port sel_i  input  1  0 = truncated unary (TRU), 1 = plain unary.
REQ-007 SHALL have port cmax_i  input  CMAX_WIDTH  truncation limit for TRU.
REQ-008 SHALL have port bin_i  input  1  serial bin, first bin first.
REQ-009 SHALL have port bin_valid_i  input  1  bin_i is valid.
REQ-010 SHALL have port bin_ready_o  output  1  block accepts a bin this cycle.
REQ-011 SHALL have port value_o  output  VALUE_WIDTH  decoded value.
REQ-012 SHALL have port bin_count_o  output  VALUE_WIDTH+1  number of bins consumed.
REQ-013 SHALL have port done_o  output  1  decode complete, value_o and bin_count_o valid.
REQ-014 SHALL have port error_o  output  1  unary overflow detected.

Function
REQ-015 SHALL implement FSM states IDLE, DECODE, DONE.
REQ-016 SHALL, on start_i=1 in any state, latch sel_i and cmax_i, clear value, bin count, done_o and error_o, and enter DECODE next cycle.
REQ-017 SHALL, when start_i=1 with sel_i=0 and cmax_i=0, go directly to DONE with value_o=0, bin_count_o=0, no bins consumed.
REQ-018 SHALL drive bin_ready_o=1 only in DECODE with start_i=0; a bin is accepted only when bin_valid_i and bin_ready_o are both 1.
REQ-019 SHALL, on an accepted bin 1, increment value and bin count by one.
REQ-020 SHALL, on an accepted bin 0, increment bin count only and enter DONE.
REQ-021 SHALL, in TRU mode, enter DONE without waiting for a 0 bin when the accepted 1 bin brings value to latched cMax (no trailing zero).
REQ-022 SHALL, in unary mode, set error_o=1 and enter DONE when an accepted 1 bin would take value beyond 2^VALUE_WIDTH-1; value_o saturates at 2^VALUE_WIDTH-1.
REQ-023 SHALL assert done_o the cycle after the terminating bin is accepted, and hold done_o, value_o, bin_count_o and error_o until the next start_i or reset.
REQ-024 SHALL ignore bin_valid_i in IDLE and DONE; bins there are not consumed.
REQ-025 SHALL give start_i priority over a simultaneous bin accept; that bin is not consumed.
REQ-026 SHALL compare value against cMax zero-extended to VALUE_WIDTH bits.
REQ-027 SHALL tolerate bin_valid_i gaps of any length in DECODE without state change.

Reset
REQ-028 SHALL, on rst=1, asynchronously enter IDLE with bin_ready_o=0, value_o=0, bin_count_o=0, done_o=0, error_o=0.
REQ-029 SHALL abandon a decode in progress when rst asserts mid-operation, with no output pulse on release.
REQ-030 SHALL remain in IDLE after rst release until start_i.

Structure
REQ-031 SHALL take the FSM state enum and mode constants (MODE_TRU=0, MODE_UNARY=1) from shared package binarization_pkg.
REQ-032 SHALL be a single module; no sub-module required.

Verification
REQ-033 SHALL cover TRU, cMax=5, bins 1,1,1,0 -> value_o=3, bin_count_o=4, done_o the cycle after the 0 bin.
REQ-034 SHALL cover TRU, cMax=5, bins 1,1,1,1,1 -> value_o=5, bin_count_o=5, bin_ready_o low afterwards, sixth bin not consumed.
REQ-035 SHALL cover unary, bins 1x7 then 0 with bin_valid_i toggling every other cycle -> value_o=7, bin_count_o=8.
REQ-036 SHALL cover TRU, cMax=0 -> done_o next cycle, value_o=0, bin_count_o=0, bin_ready_o never high.
REQ-037 SHALL cover unary, 256 consecutive 1 bins (VALUE_WIDTH=8) -> error_o=1, value_o=255, done_o=1.
REQ-038 SHALL cover rst pulse after two accepted 1 bins, then start_i and bin 0 -> value_o=0, bin_count_o=1, no stale state.
